// File: rtl/pred_upd_ctrl_if.sv
// Resolve-record, PHT port and GHR repair signals shared between the branch
// update controller and its environment.
interface pred_upd_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 14
);
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic              res_taken;
  logic              res_pred;
  logic [GHR_W-1:0]  res_ghr;
  logic              lk_req;
  logic [GHR_W-1:0]  pht_addr;
  logic              pht_rd_en;
  logic [1:0]        pht_rd_data;
  logic              pht_wr_en;
  logic [1:0]        pht_wr_data;
  logic              ghr_re_en;
  logic [GHR_W-1:0]  ghr_re_data;
  logic              busy;
  logic [15:0]       mispred_cnt;

  modport slave (
    input  res_valid, res_addr, res_taken, res_pred, res_ghr, lk_req, pht_rd_data,
    output res_ready, pht_addr, pht_rd_en, pht_wr_en, pht_wr_data,
           ghr_re_en, ghr_re_data, busy, mispred_cnt
  );

  modport master (
    output res_valid, res_addr, res_taken, res_pred, res_ghr, lk_req, pht_rd_data,
    input  res_ready, pht_addr, pht_rd_en, pht_wr_en, pht_wr_data,
           ghr_re_en, ghr_re_data, busy, mispred_cnt
  );
endinterface

// File: rtl/pred_upd_ctrl.sv
// Branch predictor update controller: queues resolved branches, performs the
// PHT read-modify-write around fetch lookups and issues immediate GHR repairs.
module pred_upd_ctrl #(
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 14,
    parameter int DEPTH  = 4
) (
    input logic           clk,
    input logic           reset,
    pred_upd_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

  // Saturating 2-bit counter step; a saturated counter is rewritten unchanged.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) ctr_next = (c == 2'd3) ? 2'd3 : c + 2'd1;
    else       ctr_next = (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic              rd_pend_r;
  logic [1:0]        hold_r;
  logic              ghr_re_en_r;
  logic [GHR_W-1:0]  ghr_re_data_r;
  logic [15:0]       mispred_cnt_r;

  logic [ADDR_W-1:0] q_addr_r  [DEPTH];
  logic              q_taken_r [DEPTH];
  logic [GHR_W-1:0]  q_ghr_r   [DEPTH];

  logic              full_s, push_s, pop_s, mis_s;
  logic              rd_en_s, wr_en_s;
  logic [GHR_W-1:0]  addr_s, head_idx_s;
  logic [1:0]        wdata_s, ctr_s;

  assign full_s     = (count_r == FULL_CNT);
  assign push_s     = bus.res_valid && !full_s;
  assign mis_s      = push_s && (bus.res_taken != bus.res_pred);
  assign head_idx_s = q_ghr_r[rd_ptr_r] ^ q_addr_r[rd_ptr_r][GHR_W-1:0];
  // In the WR entry cycle the read data is still on the bus, not yet held.
  assign ctr_s      = rd_pend_r ? bus.pht_rd_data : hold_r;

  // Next-state and PHT strobe decode; lookup requests always win the port.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;
    addr_s      = '0;
    wdata_s     = 2'd0;
    pop_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != '0) state_nxt_s = S_RD;
        else               state_nxt_s = S_IDLE;
      end
      S_RD: begin
        if (!bus.lk_req) begin
          rd_en_s     = 1'b1;
          addr_s      = head_idx_s;
          state_nxt_s = S_WR;
        end else begin
          state_nxt_s = S_RD;
        end
      end
      S_WR: begin
        if (!bus.lk_req) begin
          wr_en_s     = 1'b1;
          addr_s      = head_idx_s;
          wdata_s     = ctr_next(ctr_s, q_taken_r[rd_ptr_r]);
          pop_s       = 1'b1;
          state_nxt_s = (count_r != CW'(1)) ? S_RD : S_IDLE;
        end else begin
          state_nxt_s = S_WR;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Control state, queue occupancy, read-data hold and mispredict bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      count_r       <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      rd_pend_r     <= 1'b0;
      hold_r        <= 2'd0;
      ghr_re_en_r   <= 1'b0;
      ghr_re_data_r <= '0;
      mispred_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      rd_pend_r <= rd_en_s;
      if (rd_pend_r) hold_r <= bus.pht_rd_data;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      ghr_re_en_r <= mis_s;
      if (mis_s) ghr_re_data_r <= {bus.res_ghr[GHR_W-2:0], bus.res_taken};
      if (mis_s && (mispred_cnt_r != 16'hFFFF)) mispred_cnt_r <= mispred_cnt_r + 16'd1;
    end
  end

  // Queue storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_addr_r[wr_ptr_r]  <= bus.res_addr;
      q_taken_r[wr_ptr_r] <= bus.res_taken;
      q_ghr_r[wr_ptr_r]   <= bus.res_ghr;
    end
  end

  assign bus.res_ready   = !full_s;
  assign bus.pht_rd_en   = rd_en_s;
  assign bus.pht_wr_en   = wr_en_s;
  assign bus.pht_addr    = addr_s;
  assign bus.pht_wr_data = wdata_s;
  assign bus.ghr_re_en   = ghr_re_en_r;
  assign bus.ghr_re_data = ghr_re_data_r;
  assign bus.mispred_cnt = mispred_cnt_r;
  assign bus.busy        = (count_r != '0) || (state_r != S_IDLE);
endmodule
